kernel_buffer_ctrl: RTL and testbench

KERNEL_BUFFER_CTRL -- requirements
Module: kernel_buffer_ctrl

---
 rtl/kernel_buffer_ctrl_pkg.sv | 26 ++
 rtl/kernel_buffer_ctrl_addr_gen.sv | 49 ++++
 rtl/kernel_buffer_ctrl.sv | 147 ++++++++++++++
 tb/tb_kernel_buffer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_buffer_ctrl_pkg.sv
// Shared definitions for the kernel buffer controller.
// io_bundle field positions must match the buffer wrapper.
package kernel_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int IO_INPUT_LSB = 0;

    function automatic int io_sel_pos(input int w, input int d);
        return w + d + 1;
    endfunction

    function automatic int io_wr_pos(input int w, input int d);
        return w + d;
    endfunction

    function automatic int io_bank_lsb(input int w);
        return w;
    endfunction

endpackage

// File: rtl/kernel_buffer_ctrl_addr_gen.sv
// Row/bank counters and wrapped buffer address for load and read jobs.
module kbc_addr_gen
    import kernel_buffer_ctrl_pkg::*;
#(
    parameter int depth = 2,
    parameter int A     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    input  logic               read_mode,
    input  logic [A-1:0]       base,
    output logic [A+depth-1:0] count,
    output logic [depth-1:0]   bank,
    output logic [A-1:0]       address
);

    logic [A+depth-1:0] count_q;
    logic [depth-1:0]   bank_q;
    logic [A-1:0]       row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            bank_q  <= '0;
            row_q   <= '0;
        end else if (clear) begin
            count_q <= '0;
            bank_q  <= '0;
            row_q   <= '0;
        end else if (advance) begin
            count_q <= count_q + (A+depth)'(1);
            // reads step one row per transfer; loads fill every bank first
            if (read_mode) begin
                row_q <= row_q + A'(1);
            end else begin
                bank_q <= bank_q + depth'(1);
                if (bank_q == '1)
                    row_q <= row_q + A'(1);
            end
        end
    end

    assign count   = count_q;
    assign bank    = bank_q;
    assign address = base + row_q;

endmodule

// File: rtl/kernel_buffer_ctrl.sv
// Kernel weight buffer controller: banked weight loads and row reads
// for the convolutional unit.
module kernel_buffer_ctrl
    import kernel_buffer_ctrl_pkg::*;
#(
    parameter int depth = 2,
    parameter int A     = 7,
    parameter int W     = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start_load,
    input  logic               start_read,
    input  logic [A-1:0]       base_addr,
    input  logic [A+depth-1:0] job_len,
    input  logic [W-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               rd_ready,
    output logic [A-1:0]       address,
    output logic [W+depth+1:0] io_bundle,
    output logic               op_valid,
    output logic               op_last,
    output logic               busy,
    output logic               done
);

    localparam int L    = A + depth;
    localparam int SEL  = io_sel_pos(W, depth);
    localparam int WR   = io_wr_pos(W, depth);
    localparam int BANK = io_bank_lsb(W);

    state_t state, state_nx;

    logic [A-1:0]     base_q;
    logic [L-1:0]     len_q;
    logic [L-1:0]     count;
    logic [depth-1:0] bank;
    logic [A-1:0]     gen_addr;
    logic [L-1:0]     read_len;
    logic             load_go, read_go, skip;
    logic             accept, issue, at_last;
    logic             done_q, opv_q, opl_q;

    assign read_len = {{depth{1'b0}}, job_len[A-1:0]};
    assign load_go  = state == ST_IDLE && start_load && job_len != '0;
    assign read_go  = state == ST_IDLE && !start_load && start_read
                      && read_len != '0;
    assign skip     = state == ST_IDLE
                      && (start_load ? (job_len == '0)
                                     : (start_read && read_len == '0));
    assign accept   = state == ST_LOAD && in_valid;
    assign issue    = state == ST_READ && rd_ready;
    assign at_last  = count == len_q - L'(1);

    kbc_addr_gen #(
        .depth(depth),
        .A    (A)
    ) u_addr_gen (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clear    (load_go | read_go),
        .advance  (accept | issue),
        .read_mode(state == ST_READ),
        .base     (base_q),
        .count    (count),
        .bank     (bank),
        .address  (gen_addr)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (load_go)
                    state_nx = ST_LOAD;
                else if (read_go)
                    state_nx = ST_READ;
            end
            ST_LOAD:  if (accept && at_last) state_nx = ST_IDLE;
            ST_READ:  if (issue && at_last) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        address   = '0;
        io_bundle = '0;
        unique case (state)
            ST_LOAD: begin
                in_ready                   = 1'b1;
                busy                       = 1'b1;
                address                    = gen_addr;
                io_bundle[SEL]             = 1'b1;
                io_bundle[WR]              = in_valid;
                io_bundle[BANK +: depth]   = bank;
                io_bundle[IO_INPUT_LSB +: W] = in_data;
            end
            ST_READ, ST_DRAIN: begin
                busy    = 1'b1;
                address = gen_addr;
            end
            default: ;
        endcase
    end

    // job parameters are latched once so the inputs may change mid-job
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            base_q <= '0;
            len_q  <= '0;
        end else if (load_go) begin
            base_q <= base_addr;
            len_q  <= job_len;
        end else if (read_go) begin
            base_q <= base_addr;
            len_q  <= read_len;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done_q <= 1'b0;
            opv_q  <= 1'b0;
            opl_q  <= 1'b0;
        end else begin
            done_q <= skip | ((accept | issue) & at_last);
            opv_q  <= issue;
            opl_q  <= issue & at_last;
        end
    end

    assign done     = done_q;
    assign op_valid = opv_q;
    assign op_last  = opl_q;

endmodule

// File: tb/tb_kernel_buffer_ctrl.sv
// Directed bench for kernel_buffer_ctrl with a job-level reference
// model checked every cycle plus literal buffer-content expectations.
module tb_kernel_buffer_ctrl;

    localparam int DEPTH = 2;
    localparam int AW    = 7;
    localparam int WW    = 16;
    localparam int D     = 1 << DEPTH;
    localparam int BW    = WW + DEPTH + 2;
    localparam int AMOD  = 1 << AW;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start_load = 1'b0;
    logic              start_read = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW+DEPTH-1:0] job_len = '0;
    logic [WW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              rd_ready = 1'b0;
    logic [AW-1:0]     address;
    logic [BW-1:0]     io_bundle;
    logic              op_valid;
    logic              op_last;
    logic              busy;
    logic              done;

    int n_vec = 0;
    int n_err = 0;
    int mem [0:AMOD-1][0:D-1];

    kernel_buffer_ctrl #(
        .depth(DEPTH),
        .A    (AW),
        .W    (WW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start_load(start_load),
        .start_read(start_read),
        .base_addr (base_addr),
        .job_len   (job_len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rd_ready  (rd_ready),
        .address   (address),
        .io_bundle (io_bundle),
        .op_valid  (op_valid),
        .op_last   (op_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Job-level model: mode 0 idle, 1 load, 2 read, 3 drain.
    int m_mode, m_base, m_len, m_k;
    bit m_done, m_opv, m_opl;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_mode <= 0; m_base <= 0; m_len <= 0; m_k <= 0;
            m_done <= 0; m_opv <= 0; m_opl <= 0;
        end else begin
            m_done <= 0; m_opv <= 0; m_opl <= 0;
            case (m_mode)
                0: if (start_load) begin
                    if (job_len == 0) m_done <= 1;
                    else begin
                        m_mode <= 1; m_base <= base_addr;
                        m_len <= job_len; m_k <= 0;
                    end
                end else if (start_read) begin
                    if (job_len % AMOD == 0) m_done <= 1;
                    else begin
                        m_mode <= 2; m_base <= base_addr;
                        m_len <= job_len % AMOD; m_k <= 0;
                    end
                end
                1: if (in_valid) begin
                    m_k <= m_k + 1;
                    if (m_k + 1 == m_len) begin
                        m_mode <= 0; m_done <= 1;
                    end
                end
                2: if (rd_ready) begin
                    m_opv <= 1; m_k <= m_k + 1;
                    if (m_k + 1 == m_len) begin
                        m_opl <= 1; m_mode <= 3; m_done <= 1;
                    end
                end
                default: m_mode <= 0;
            endcase
        end
    end

    always @(negedge CLK) begin
        logic [BW-1:0] eb;
        chk("busy", busy, m_mode != 0);
        chk("in_ready", in_ready, m_mode == 1);
        chk("done", done, m_done);
        chk("op_valid", op_valid, m_opv);
        chk("op_last", op_last, m_opl);
        if (m_mode == 0)
            chk("idle_io_bundle", io_bundle, 0);
        if (m_mode == 1) begin
            eb = '0;
            eb[BW-1] = 1'b1;
            eb[BW-2] = in_valid;
            eb[WW +: DEPTH] = DEPTH'(m_k % D);
            eb[WW-1:0] = in_data;
            chk("load_io_bundle", io_bundle, eb);
            chk("load_address", address, (m_base + m_k / D) % AMOD);
        end
        if (m_mode == 2) begin
            chk("read_address", address, (m_base + m_k) % AMOD);
            chk("read_sel_wr", io_bundle[BW-1:BW-2], 0);
        end
        if (io_bundle[BW-1] && io_bundle[BW-2])
            mem[address][io_bundle[WW +: DEPTH]] = int'(io_bundle[WW-1:0]);
    end

    task automatic step;
        @(posedge CLK);
        #2;
    endtask

    task automatic load_job(input int base, input int len, input int first,
                            input bit gaps, input bit both);
        int j;
        int c;
        start_load = 1'b1;
        start_read = both;
        base_addr = AW'(base);
        job_len = (AW+DEPTH)'(len);
        step;
        start_load = 1'b0;
        start_read = 1'b0;
        chk("load_in_ready", in_ready, 1);
        j = 0;
        c = 0;
        while (j < len && c < 4 * len + 8) begin
            in_valid = !(gaps && (c % 3 == 1));
            in_data = WW'(first + j);
            start_read = gaps && c == 1;
            if (gaps && c == 1) begin
                base_addr = 7'd99;
                job_len = 9'd3;
            end
            step;
            start_read = 1'b0;
            if (in_valid) j++;
            c++;
        end
        in_valid = 1'b0;
        chk("load_done_pulse", done, 1);
        chk("load_end_busy", busy, 0);
    endtask

    task automatic read_job(input int base, input int len,
                            input logic [7:0] pat);
        int c;
        start_read = 1'b1;
        base_addr = AW'(base);
        job_len = (AW+DEPTH)'(len);
        step;
        start_read = 1'b0;
        c = 0;
        while (busy && c < 64) begin
            rd_ready = pat[c % 8];
            step;
            c++;
        end
        rd_ready = 1'b0;
        chk("read_timeout_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < AMOD; a++)
            for (int b = 0; b < D; b++)
                mem[a][b] = -1;

        repeat (3) step;
        chk("rst_busy", busy, 0);
        chk("rst_address", address, 0);
        chk("rst_io_bundle", io_bundle, 0);
        chk("rst_flags", {in_ready, op_valid, op_last, done}, 0);
        RST_N = 1'b1;
        step;

        load_job(5, 8, 1, 1'b0, 1'b0);
        for (int b = 0; b < D; b++) begin
            chk($sformatf("mem5_b%0d", b), mem[5][b], b + 1);
            chk($sformatf("mem6_b%0d", b), mem[6][b], b + 5);
        end
        step;
        chk("load_done_one_cycle", done, 0);

        base_addr = 7'd5;
        job_len = 9'd2;
        start_read = 1'b1;
        step;
        start_read = 1'b0;
        rd_ready = 1'b1;
        chk("r_c1_addr", address, 5);
        chk("r_c1_opv", op_valid, 0);
        step;
        rd_ready = 1'b0;
        chk("r_c2_addr", address, 6);
        chk("r_c2_opv", op_valid, 1);
        chk("r_c2_opl", op_last, 0);
        step;
        rd_ready = 1'b1;
        chk("r_c3_addr", address, 6);
        chk("r_c3_opv", op_valid, 0);
        step;
        rd_ready = 1'b0;
        chk("r_c4_opv", op_valid, 1);
        chk("r_c4_opl", op_last, 1);
        chk("r_c4_done", done, 1);
        chk("r_c4_busy", busy, 1);
        step;
        chk("r_c5_busy", busy, 0);
        chk("r_c5_done", done, 0);

        load_job(127, 8, 'h11, 1'b0, 1'b0);
        chk("wrap_mem127_b0", mem[127][0], 'h11);
        chk("wrap_mem127_b3", mem[127][3], 'h14);
        chk("wrap_mem0_b0", mem[0][0], 'h15);
        chk("wrap_mem0_b3", mem[0][3], 'h18);

        load_job(20, 4, 'h51, 1'b1, 1'b1);
        for (int b = 0; b < D; b++)
            chk($sformatf("both_mem20_b%0d", b), mem[20][b], 'h51 + b);
        step;
        chk("both_no_read_busy", busy, 0);

        start_load = 1'b1;
        job_len = '0;
        step;
        start_load = 1'b0;
        chk("zl_load_done", done, 1);
        chk("zl_load_io", io_bundle, 0);
        step;
        chk("zl_load_done_off", done, 0);
        start_read = 1'b1;
        step;
        start_read = 1'b0;
        chk("zl_read_done", done, 1);
        chk("zl_read_busy", busy, 0);
        step;

        read_job(126, 3, 8'hFF);
        read_job(10, 4, 8'b1011_0010);
        read_job(40, 1, 8'h01);

        start_load = 1'b1;
        base_addr = '0;
        job_len = 9'd8;
        in_valid = 1'b1;
        step;
        start_load = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_data = WW'('h30 + j);
            step;
        end
        RST_N = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_io", io_bundle, 0);
        chk("mid_rst_addr", address, 0);
        chk("mid_rst_flags", {in_ready, op_valid, op_last, done}, 0);
        step;
        step;
        chk("mid_rst_no_done", done, 0);
        in_valid = 1'b0;
        RST_N = 1'b1;
        step;
        chk("post_rst_done", done, 0);
        load_job(0, 8, 'h41, 1'b0, 1'b0);
        for (int b = 0; b < D; b++) begin
            chk($sformatf("post_mem0_b%0d", b), mem[0][b], 'h41 + b);
            chk($sformatf("post_mem1_b%0d", b), mem[1][b], 'h45 + b);
        end
        step;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
